// File: rtl/dmem_write_buffer.sv
// Posted store FIFO in front of a slow handshaked data RAM. Loads forward from the
// youngest matching buffered store, otherwise the pipeline stalls while RAM is read.
module dmem_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memwrite_i,
    input  logic          memread_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o,
    output logic          stall_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-3:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic          mem_ack_i,
    input  logic [31:0]   mem_rdata_i
);

    localparam int          PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, LOAD, LDONE} state_t;

    state_t        state;
    logic [AW-3:0] fifo_addr [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;
    logic [31:0]   ldata;

    logic [AW-3:0] word_addr;
    logic          unused_addr_bits;
    logic          full;
    logic          push;
    logic          pop;
    logic          match;
    logic          hit;
    logic          miss;
    logic [31:0]   match_data;
    logic [PW-1:0] idx;

    assign word_addr        = addr_i[AW-1:2];
    assign unused_addr_bits = ^addr_i[1:0];
    assign full             = (count == FULL_COUNT);
    assign push             = memwrite_i & ~full;
    assign pop              = (state == DRAIN) & mem_ack_i;

    // Walk entries oldest to youngest so the last assignment is the youngest match.
    always_comb begin
        match      = 1'b0;
        match_data = '0;
        idx        = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (((PW+1)'(i) < count) && (fifo_addr[idx] == word_addr)) begin
                match      = 1'b1;
                match_data = fifo_data[idx];
            end
        end
    end

    assign hit     = memread_i & match;
    assign miss    = memread_i & ~match;
    assign stall_o = (memwrite_i & full) | (miss & (state != LDONE));
    assign rdata_o = (hit && (state != LDONE)) ? match_data : ldata;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[tail] <= word_addr;
            fifo_data[tail] <= wdata_i;
        end
    end

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            if (push && !pop)      count <= count + (PW+1)'(1);
            else if (pop && !push) count <= count - (PW+1)'(1);
        end
    end

    // IDLE always separates RAM transactions, so requests can never overlap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ldata       <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        state      <= LOAD;
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= word_addr;
                    end else if (count != '0) begin
                        state       <= DRAIN;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= fifo_addr[head];
                        mem_wdata_o <= fifo_data[head];
                    end
                end
                DRAIN: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        state     <= IDLE;
                    end
                end
                LOAD: begin
                    if (mem_ack_i) begin
                        ldata     <= mem_rdata_i;
                        mem_req_o <= 1'b0;
                        state     <= LDONE;
                    end
                end
                LDONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed bench for dmem_write_buffer: a vector table for forwarding and fill
// behaviour, plus hand-written sequences for RAM handshakes and reset.
module tb_dmem_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          memwrite_i;
    logic          memread_i;
    logic [AW-1:0] addr_i;
    logic [31:0]   wdata_i;
    logic [31:0]   rdata_o;
    logic          stall_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-3:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic          mem_ack_i;
    logic [31:0]   mem_rdata_i;

    logic auto_en;
    logic auto_ack;
    logic manual_ack;
    int   ack_delay;
    int   wait_cnt;

    logic [31:0]   ram [logic [AW-3:0]];
    logic          log_we   [$];
    logic [AW-3:0] log_addr [$];
    logic [31:0]   log_data [$];

    int            violations;
    logic          in_txn;
    logic          t_we;
    logic [AW-3:0] t_addr;
    logic [31:0]   t_wdata;

    int total;
    int passed;

    typedef struct packed {
        logic        memwrite;
        logic        memread;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_stall;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
        logic        exp_req;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    assign mem_ack_i = auto_ack | manual_ack;

    dmem_write_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .memwrite_i  (memwrite_i),
        .memread_i   (memread_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    // RAM responder: acks after ack_delay extra request cycles
    always @(negedge clk) begin
        if (reset || !mem_req_o || !auto_en) begin
            auto_ack = 1'b0;
            wait_cnt = 0;
        end else if (auto_ack) begin
            auto_ack = 1'b0;
        end else if (wait_cnt >= ack_delay) begin
            auto_ack = 1'b1;
            wait_cnt = 0;
        end else begin
            wait_cnt++;
        end
        mem_rdata_i = ram.exists(mem_addr_o) ? ram[mem_addr_o] : 32'h0;
    end

    // Transaction log and request-stability monitor
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            in_txn = 1'b0;
        end else if (mem_req_o) begin
            if (in_txn && (mem_we_o !== t_we || mem_addr_o !== t_addr || mem_wdata_o !== t_wdata))
                violations++;
            if (mem_ack_i) begin
                in_txn = 1'b0;
                log_we.push_back(mem_we_o);
                log_addr.push_back(mem_addr_o);
                log_data.push_back(mem_wdata_o);
                if (mem_we_o) ram[mem_addr_o] = mem_wdata_o;
            end else begin
                in_txn  = 1'b1;
                t_we    = mem_we_o;
                t_addr  = mem_addr_o;
                t_wdata = mem_wdata_o;
            end
        end else begin
            in_txn = 1'b0;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
    endtask

    task automatic check_log(input string nm, input int i, input logic we,
                             input logic [AW-3:0] a, input logic [31:0] d, input logic chk_d);
        if (i >= log_we.size()) begin
            total++;
            $display("[TB] FAIL %s: got no RAM transaction %0d, expected one", nm, i);
        end else begin
            check({nm, " we"}, 32'(log_we[i]), 32'(we));
            check({nm, " addr"}, 32'(log_addr[i]), 32'(a));
            if (chk_d) check({nm, " data"}, log_data[i], d);
        end
    endtask

    // Issue a load, count stall cycles (bounded), then check the returned data.
    task automatic load_check(input string nm, input logic [31:0] a,
                              input logic [31:0] exp_data, input int exp_stalls);
        int n;
        n = 0;
        memread_i = 1'b1;
        addr_i    = a;
        #1;
        while (stall_o && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({nm, " stall cycles"}, 32'(n), 32'(exp_stalls));
        check({nm, " rdata"}, rdata_o, exp_data);
        @(negedge clk);
        memread_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total = 0; passed = 0; violations = 0;
        reset = 1'b1; memwrite_i = 1'b0; memread_i = 1'b0;
        addr_i = '0; wdata_i = '0;
        auto_en = 1'b0; auto_ack = 1'b0; manual_ack = 1'b0;
        ack_delay = 0; wait_cnt = 0; mem_rdata_i = '0; in_txn = 1'b0;
        ram[30'h0C0] = 32'hDEADBEEF;
        ram[30'h180] = 32'hCAFEF00D;
        ram[30'h1C0] = 32'h0BADF00D;

        //               wr    rd    addr          wdata         stall chk   exp_rdata     req
        vecs[0]  = '{1'b1, 1'b0, 32'h100, 32'h11111111, 1'b0, 1'b0, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'h100, 32'h0,        1'b0, 1'b1, 32'h11111111, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h200, 32'hAAAA0001, 1'b0, 1'b0, 32'h0,        1'b1};
        vecs[3]  = '{1'b1, 1'b0, 32'h200, 32'hBBBB0002, 1'b0, 1'b0, 32'h0,        1'b1};
        vecs[4]  = '{1'b0, 1'b1, 32'h200, 32'h0,        1'b0, 1'b1, 32'hBBBB0002, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 32'h103, 32'h0,        1'b0, 1'b1, 32'h11111111, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 32'h204, 32'hCCCC0003, 1'b0, 1'b0, 32'h0,        1'b1};
        vecs[7]  = '{1'b1, 1'b0, 32'h208, 32'hDDDD0004, 1'b1, 1'b0, 32'h0,        1'b1};
        vecs[8]  = '{1'b0, 1'b1, 32'h204, 32'h0,        1'b0, 1'b1, 32'hCCCC0003, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 1'b1, 32'h208, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1};
        vecs[11] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,        1'b1};

        #1;
        check("reset req", 32'(mem_req_o), 32'h0);
        check("reset we", 32'(mem_we_o), 32'h0);
        check("reset addr", 32'(mem_addr_o), 32'h0);
        check("reset wdata", mem_wdata_o, 32'h0);
        check("reset rdata", rdata_o, 32'h0);
        check("reset stall", 32'(stall_o), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Forwarding, youngest-wins and full behaviour with the RAM never acking
        for (int i = 0; i < 12; i++) begin
            memwrite_i = vecs[i].memwrite;
            memread_i  = vecs[i].memread;
            addr_i     = vecs[i].addr;
            wdata_i    = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d stall", i), 32'(stall_o), 32'(vecs[i].exp_stall));
            if (vecs[i].chk_rdata) check($sformatf("vec%0d rdata", i), rdata_o, vecs[i].exp_rdata);
            check($sformatf("vec%0d req", i), 32'(mem_req_o), 32'(vecs[i].exp_req));
            if (vecs[i].exp_req) begin
                check($sformatf("vec%0d mem_addr", i), 32'(mem_addr_o), 32'h40);
                check($sformatf("vec%0d mem_we", i), 32'(mem_we_o), 32'h1);
            end
            @(negedge clk);
        end
        memwrite_i = 1'b0; memread_i = 1'b0;

        log_we.delete(); log_addr.delete(); log_data.delete();
        auto_en = 1'b1;
        repeat (20) @(negedge clk);
        check("drain count", 32'(log_we.size()), 32'd4);
        check_log("drain0", 0, 1'b1, 30'h40, 32'h11111111, 1'b1);
        check_log("drain1", 1, 1'b1, 30'h80, 32'hAAAA0001, 1'b1);
        check_log("drain2", 2, 1'b1, 30'h80, 32'hBBBB0002, 1'b1);
        check_log("drain3", 3, 1'b1, 30'h81, 32'hCCCC0003, 1'b1);
        load_check("reload 0x100", 32'h100, 32'h11111111, 2);

        // Five back-to-back stores with no ack, then a single manual ack
        auto_en = 1'b0;
        log_we.delete(); log_addr.delete(); log_data.delete();
        for (int i = 0; i < 5; i++) begin
            memwrite_i = 1'b1;
            addr_i     = 32'h400 + 32'(4 * i);
            wdata_i    = 32'h50000000 + 32'(i);
            #1;
            check($sformatf("fill%0d stall", i), 32'(stall_o), 32'(i == 4));
            @(negedge clk);
        end
        manual_ack = 1'b1;
        #1;
        check("full ack stall", 32'(stall_o), 32'h1);
        check("full ack req", 32'(mem_req_o), 32'h1);
        @(negedge clk);
        manual_ack = 1'b0;
        #1;
        check("after pop stall", 32'(stall_o), 32'h0);
        @(negedge clk);
        addr_i  = 32'h414;
        wdata_i = 32'h50000005;
        #1;
        check("refilled stall", 32'(stall_o), 32'h1);
        @(negedge clk);
        memwrite_i = 1'b0;
        auto_en    = 1'b1;
        repeat (20) @(negedge clk);
        check("fill drain count", 32'(log_we.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            check_log($sformatf("fill drain%0d", i), i, 1'b1, 30'h100 + 30'(i),
                      32'h50000000 + 32'(i), 1'b1);

        // Plain miss with ack in the first request cycle
        log_we.delete(); log_addr.delete(); log_data.delete();
        load_check("miss 0x300", 32'h300, 32'hDEADBEEF, 2);
        check("miss txn count", 32'(log_we.size()), 32'd1);
        check_log("miss read", 0, 1'b0, 30'h0C0, 32'h0, 1'b0);

        // Miss arriving while a drain waits on a slow ack
        log_we.delete(); log_addr.delete(); log_data.delete();
        ack_delay  = 3;
        memwrite_i = 1'b1;
        addr_i     = 32'h500;
        wdata_i    = 32'h12345678;
        #1;
        check("slow store stall", 32'(stall_o), 32'h0);
        @(negedge clk);
        memwrite_i = 1'b0;
        @(negedge clk);
        load_check("miss during drain", 32'h600, 32'hCAFEF00D, 9);
        check("slow txn count", 32'(log_we.size()), 32'd2);
        check_log("slow write", 0, 1'b1, 30'h140, 32'h12345678, 1'b1);
        check_log("slow read", 1, 1'b0, 30'h180, 32'h0, 1'b0);
        ack_delay = 0;

        // Asynchronous reset in the middle of a drain
        auto_en = 1'b0;
        log_we.delete(); log_addr.delete(); log_data.delete();
        memwrite_i = 1'b1;
        addr_i     = 32'h700;
        wdata_i    = 32'h77777777;
        @(negedge clk);
        memwrite_i = 1'b0;
        @(negedge clk);
        #1;
        check("pre-reset req", 32'(mem_req_o), 32'h1);
        check("pre-reset we", 32'(mem_we_o), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("mid reset req", 32'(mem_req_o), 32'h0);
        check("mid reset we", 32'(mem_we_o), 32'h0);
        check("mid reset addr", 32'(mem_addr_o), 32'h0);
        check("mid reset wdata", mem_wdata_o, 32'h0);
        check("mid reset stall", 32'(stall_o), 32'h0);
        check("mid reset rdata", rdata_o, 32'h0);
        @(negedge clk);
        reset   = 1'b0;
        auto_en = 1'b1;
        @(negedge clk);
        #1;
        check("post reset idle req", 32'(mem_req_o), 32'h0);
        @(negedge clk);
        load_check("post reset load", 32'h700, 32'h0BADF00D, 2);
        check("post reset txn count", 32'(log_we.size()), 32'd1);
        check_log("post reset read", 0, 1'b0, 30'h1C0, 32'h0, 1'b0);

        check("request stability", 32'(violations), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_write_buffer.md
# dmem_write_buffer

Posted store buffer and data-memory controller between the pipeline's Memory stage and a slow, handshaked data RAM. Stores retire in one cycle into a DEPTH-entry FIFO, which drains to RAM in the background. Loads are forwarded from the FIFO on an address hit, or fetched from RAM while the pipeline is held by `stall_o`. `stall_o` feeds the hazard unit, which must freeze F/D/E/M and bubble W.

## Interface
- DEPTH, 4: store FIFO entries, power of two, ≥2
- AW, 32: byte-address width; bits [1:0] ignored (word access only)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- memwrite_i  in  1  M-stage store valid
- memread_i  in  1  M-stage load valid (from memtoregM); never high together with memwrite_i
- addr_i  in  AW  M-stage byte address (aluoutM)
- wdata_i  in  32  store data (writedataM)
- rdata_o  out  32  load data to the readdataM pipeline register
- stall_o  out  1  hold pipeline this cycle; core keeps M-stage inputs stable while high
- mem_req_o  out  1  RAM request, registered
- mem_we_o  out  1  1 = write, 0 = read, registered
- mem_addr_o  out  AW-2  RAM word address, registered
- mem_wdata_o  out  32  RAM write data, registered
- mem_ack_i  in  1  RAM accepts/completes the current request, single-cycle pulse
- mem_rdata_i  in  32  RAM read data, valid with mem_ack_i when mem_we_o = 0

## Operation
- FIFO: circular buffer of {word addr, data}; pointers wrap modulo DEPTH; count 0..DEPTH.
- Store: accepted when memwrite_i & count<DEPTH at cycle start; pushed at the clock edge. With memwrite_i & count==DEPTH, stall_o = 1 and there is no push.
- Push and pop in the same cycle: both occur, count unchanged.
- Forward hit: memread_i and addr_i[AW-1:2] equals any valid entry. rdata_o = data of the youngest matching entry, combinational, stall_o = 0.
- Miss: a RAM read is required. Loads bypass older non-matching stores.
- FSM states: IDLE, DRAIN, LOAD, LDONE.
  - IDLE, miss pending → LOAD; drive mem_req=1, we=0, addr on the next edge.
  - IDLE, no miss, count>0 → DRAIN; drive req=1, we=1, head addr/data.
  - IDLE otherwise → IDLE. A miss has priority over a drain.
  - DRAIN: req/we/addr/wdata held stable until mem_ack_i. On ack: pop head, req=0, → IDLE.
  - LOAD: request held until mem_ack_i. On ack: capture mem_rdata_i into ldata, req=0, → LDONE.
  - LDONE: rdata_o = ldata, stall_o = 0 for exactly one cycle, → IDLE.
- stall_o = (memwrite_i & count==DEPTH) | (memread_i & ~hit & state!=LDONE). Combinational.
- rdata_o when neither a hit nor LDONE applies: ldata (don't-care to the core).
- A write already in flight completes before any read is issued. The RAM never sees overlapping requests.
- Reset (asynchronous, any time, including mid-handshake):
  - state IDLE, count 0, pointers 0, ldata 0.
  - mem_req_o / mem_we_o / mem_addr_o / mem_wdata_o all 0.
  - Buffered stores are discarded.
  - rdata_o 0, stall_o follows its equation (0 with inputs low).

## Timing
- Store latency to core: 0 stall cycles while not full. RAM write occurs ≥1 cycle later.
- Forwarded load: 0 stall cycles.
- Missed load from IDLE with ack in the first req cycle: stall cycles 0 and 1, data in cycle 2 (LDONE). Minimum 2 stall cycles; each extra RAM wait cycle adds one.
- Miss arriving during DRAIN: stall covers the remaining drain cycles, plus the IDLE cycle, plus the LOAD cycles.
- Minimum 2 cycles per RAM transaction, because IDLE sits between transactions.
- mem_ack_i outside DRAIN/LOAD is ignored.

## Test plan
- Reset mid-DRAIN: assert reset while mem_req_o=1 → next sample shows req=0, count=0, stall_o=0. A later load of that address goes to RAM.
- Store 0x11111111 @0x100, then load @0x100 next cycle → rdata_o=0x11111111 with stall_o=0. Later the RAM sees a write to word 0x40.
- Store A @0x200, store B @0x200, immediate load @0x200 → rdata_o=B (youngest wins).
- Five back-to-back stores with DEPTH=4 and mem_ack_i held low → 5th cycle stall_o=1, no push. Single ack → pop, 5th store accepted next cycle, count=4.
- Load @0x300 miss, RAM acks in the first req cycle with 0xDEADBEEF → stall_o high 2 cycles, then rdata_o=0xDEADBEEF with stall_o=0 for one cycle.
- Load miss while a drain is waiting with ack delayed 3 cycles → write completes first (we=1), then read (we=0). Requests never overlap. Final rdata_o is correct.
